// File: rtl/key_debounce_pkg.sv
// Shared types and constants for the push-button conditioning front end.
package key_debounce_pkg;

    // Per-key debounce FSM state.
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRESS_DEB = 2'd1,
        PRESSED   = 2'd2,
        REL_DEB   = 2'd3
    } key_state_t;

    // Button bit positions on key_in / key_value / key_held.
    localparam int unsigned KEY_REFUND = 0;
    localparam int unsigned KEY_HALF   = 1;
    localparam int unsigned KEY_ONE    = 2;

    // 20 ms at 50 MHz.
    localparam int unsigned DEB_CYCLES_DEFAULT = 1_000_000;
    localparam int unsigned CNT_W_DEFAULT      = 20;

    // A key counts as held from acceptance until its release is confirmed.
    function automatic logic state_is_held(key_state_t s);
        return (s == PRESSED) || (s == REL_DEB);
    endfunction

endpackage

// File: rtl/key_debounce_pulse_if.sv
// Button bundle between the board pins / test harness and the debounce stage.
interface key_debounce_pulse_if #(
    parameter int unsigned N_KEYS = 3
) ();

    logic [N_KEYS-1:0] key_in;     // raw, active-low
    logic [N_KEYS-1:0] key_value;  // one-cycle press pulse, active-low
    logic [N_KEYS-1:0] key_held;   // debounced level, active-high

    modport master (
        output key_in,
        input  key_value,
        input  key_held
    );

    modport slave (
        input  key_in,
        output key_value,
        output key_held
    );

endinterface

// File: rtl/key_debounce_cell.sv
// One button: two-flop synchroniser, debounce FSM and stability counter.
// pulse_req is high for the single cycle on which a press is accepted.
module key_debounce_cell
    import key_debounce_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEFAULT,
    parameter int unsigned CNT_W      = CNT_W_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_raw,
    output logic pulse_req,
    output logic held
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic             sync1_q, sync2_q;
    logic             key_s;
    key_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             held_q, held_d;

    assign key_s = sync2_q;

    // Synchroniser: resets to the released level so reset never looks like a press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= key_raw;
            sync2_q <= sync1_q;
        end
    end

    // Next state: a bounce always wins over a counter that has just expired.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pulse_req = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!key_s) begin
                    state_d = PRESS_DEB;
                    cnt_d   = '0;
                end
            end
            PRESS_DEB: begin
                if (key_s) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = PRESSED;
                    cnt_d     = '0;
                    pulse_req = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            PRESSED: begin
                if (key_s) begin
                    state_d = REL_DEB;
                    cnt_d   = '0;
                end
            end
            REL_DEB: begin
                if (!key_s) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        held_d = state_is_held(state_d);
    end

    // State, counter and registered held level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            held_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            held_q  <= held_d;
        end
    end

    assign held = held_q;

endmodule

// File: rtl/key_debounce_pulse.sv
// Debounce front end for the vending-machine buttons (refund, 0.5 coin, 1 coin).
// One pulse per accepted press on the active-low key_value, plus a held level.
// Optional: define KEY_LOCKOUT_EN to let a held key suppress pulses from all others,
// with the lowest index winning when several keys qualify together.
module key_debounce_pulse
    import key_debounce_pkg::*;
#(
    parameter int unsigned N_KEYS     = 3,
    parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEFAULT,
    parameter int unsigned CNT_W      = CNT_W_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    key_debounce_pulse_if.slave  bus
);

    logic [N_KEYS-1:0] pulse_req;
    logic [N_KEYS-1:0] held;
    logic [N_KEYS-1:0] grant;
    logic [N_KEYS-1:0] key_value_q, key_value_d;

    for (genvar i = 0; i < N_KEYS; i++) begin : g_cell
        key_debounce_cell #(
            .DEB_CYCLES (DEB_CYCLES),
            .CNT_W      (CNT_W)
        ) u_cell (
            .clk       (clk),
            .rst_n     (rst_n),
            .key_raw   (bus.key_in[i]),
            .pulse_req (pulse_req[i]),
            .held      (held[i])
        );
    end

`ifdef KEY_LOCKOUT_EN
    // Lockout: a qualifying key is never itself held, so any held key blocks it.
    always_comb begin
        logic taken;
        grant = '0;
        taken = 1'b0;
        if (held == '0) begin
            for (int i = 0; i < N_KEYS; i++) begin
                if (pulse_req[i] && !taken) begin
                    grant[i] = 1'b1;
                    taken    = 1'b1;
                end
            end
        end
    end
`else
    // Independent keys: every accepted press pulses.
    always_comb begin
        grant = pulse_req;
    end
`endif

    // Active-low pulse value for the output register.
    always_comb begin
        key_value_d = ~grant;
    end

    // Output register: key_value falls on the same edge that held rises.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_value_q <= '1;
        end else begin
            key_value_q <= key_value_d;
        end
    end

    assign bus.key_value = key_value_q;
    assign bus.key_held  = held;

endmodule

// File: tb/tb_key_debounce_pulse.sv
// Directed bench for key_debounce_pulse with DEB_CYCLES=4. Expected pulses are queued
// with the cycle they must appear on; a negedge monitor pops them as pulses show up.
module tb_key_debounce_pulse;
    import key_debounce_pkg::*;

    localparam int unsigned NK  = 3;
    localparam int unsigned DEB = 4;
    localparam int unsigned CW  = 8;
    // Drive at negedge with cyc=c: pulse seen at the negedge where cyc == c+DEB+3.
    localparam int LAT = DEB + 3;

    logic clk = 1'b0;
    logic rst_n;

    key_debounce_pulse_if #(.N_KEYS(NK)) bus ();

    key_debounce_pulse #(
        .N_KEYS     (NK),
        .DEB_CYCLES (DEB),
        .CNT_W      (CW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [2:0] val;
        int         at;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0;
    int errors = 0;

    task automatic check3(input string name, input logic [2:0] act, input logic [2:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%b required=%b (cyc %0d)", name, act, req, cyc);
        end
    endtask

    task automatic check_int(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (cyc %0d)", name, act, req, cyc);
        end
    endtask

    task automatic expect_pulse(input logic [2:0] v, input int at);
        exp_t e;
        e.val = v;
        e.at  = at;
        exp_q.push_back(e);
    endtask

    task automatic wait_to(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: any low bit on key_value is a pulse and must match the queue head.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1 && bus.key_value !== 3'b111) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse actual=%b required=none (cyc %0d)",
                         bus.key_value, cyc);
            end else begin
                e = exp_q.pop_front();
                check3("pulse_value", bus.key_value, e.val);
                check_int("pulse_cycle", cyc, e.at);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c;
        bus.key_in = 3'b111;
        rst_n      = 1'b1;
        #2 rst_n   = 1'b0;
        #1;
        check3("reset_key_value", bus.key_value, 3'b111);
        check3("reset_key_held", bus.key_held, 3'b000);
        idle(2);
        rst_n = 1'b1;
        idle(3);

        // 1. Clean press of the 0.5 coin key.
        c = cyc;
        bus.key_in[KEY_HALF] = 1'b0;
        expect_pulse(3'b101, c + LAT);
        wait_to(c + LAT - 1);
        check3("t1_held_before", bus.key_held, 3'b000);
        wait_to(c + LAT);
        check3("t1_held_on", bus.key_held, 3'b010);
        wait_to(c + 20);
        bus.key_in = 3'b111;
        idle(12);
        check3("t1_held_off", bus.key_held, 3'b000);
        check_int("t1_drained", exp_q.size(), 0);

        // 2. Press bounce on the 1 coin key: 3 low, 1 high, 3 low.
        c = cyc;
        bus.key_in[KEY_ONE] = 1'b0;
        wait_to(c + 3);
        bus.key_in = 3'b111;
        wait_to(c + 4);
        bus.key_in[KEY_ONE] = 1'b0;
        wait_to(c + 6);
        check3("t2_held_mid", bus.key_held, 3'b000);
        wait_to(c + 7);
        bus.key_in = 3'b111;
        idle(12);
        check3("t2_held_end", bus.key_held, 3'b000);
        check_int("t2_drained", exp_q.size(), 0);

        // 3. Release bounce: 2-cycle highs never complete the release debounce.
        c = cyc;
        bus.key_in[KEY_HALF] = 1'b0;
        expect_pulse(3'b101, c + LAT);
        wait_to(c + 10);
        for (int k = 0; k < 4; k++) begin
            bus.key_in[KEY_HALF] = (k % 2 == 0);
            idle(2);
        end
        bus.key_in[KEY_HALF] = 1'b0;
        idle(10);
        check3("t3_held_through_bounce", bus.key_held, 3'b010);
        bus.key_in = 3'b111;
        idle(12);
        check_int("t3_drained", exp_q.size(), 0);

        // 4a. Re-press after a 6-cycle release: two pulses.
        c = cyc;
        bus.key_in[KEY_ONE] = 1'b0;
        expect_pulse(3'b011, c + LAT);
        wait_to(c + 10);
        bus.key_in = 3'b111;
        wait_to(c + 16);
        bus.key_in[KEY_ONE] = 1'b0;
        expect_pulse(3'b011, c + 16 + LAT);
        wait_to(c + 30);
        bus.key_in = 3'b111;
        idle(12);
        check_int("t4a_drained", exp_q.size(), 0);

        // 4b. Release of only 3 cycles: still one press.
        c = cyc;
        bus.key_in[KEY_ONE] = 1'b0;
        expect_pulse(3'b011, c + LAT);
        wait_to(c + 10);
        bus.key_in = 3'b111;
        wait_to(c + 13);
        bus.key_in[KEY_ONE] = 1'b0;
        wait_to(c + 25);
        check3("t4b_held", bus.key_held, 3'b100);
        bus.key_in = 3'b111;
        idle(12);
        check_int("t4b_drained", exp_q.size(), 0);

        // 5. Reset mid-debounce on refund, key still held after reset.
        c = cyc;
        bus.key_in[KEY_REFUND] = 1'b0;
        wait_to(c + 3);
        rst_n = 1'b0;
        #1;
        check3("t5_rst_value", bus.key_value, 3'b111);
        check3("t5_rst_held", bus.key_held, 3'b000);
        idle(1);
        idle(1);
        rst_n = 1'b1;
        expect_pulse(3'b110, c + 5 + LAT);
        wait_to(c + 20);
        check3("t5_held_after", bus.key_held, 3'b001);
        // Reset while held must clear key_held at once.
        rst_n = 1'b0;
        #1;
        check3("t5_rst_held_clear", bus.key_held, 3'b000);
        bus.key_in = 3'b111;
        @(negedge clk);
        rst_n = 1'b1;
        idle(12);
        check_int("t5_drained", exp_q.size(), 0);

        // 6. Refund and 1 coin pressed on the same edge.
        c = cyc;
        bus.key_in = 3'b010;
`ifdef KEY_LOCKOUT_EN
        expect_pulse(3'b110, c + LAT);
`else
        expect_pulse(3'b010, c + LAT);
`endif
        wait_to(c + 20);
        check3("t6_held", bus.key_held, 3'b101);
        bus.key_in = 3'b111;
        idle(12);
        check_int("t6_drained", exp_q.size(), 0);

        // 7. 0.5 coin pressed while refund is held.
        c = cyc;
        bus.key_in[KEY_REFUND] = 1'b0;
        expect_pulse(3'b110, c + LAT);
        wait_to(c + 10);
        bus.key_in[KEY_HALF] = 1'b0;
`ifndef KEY_LOCKOUT_EN
        expect_pulse(3'b101, c + 10 + LAT);
`endif
        wait_to(c + 22);
        check3("t7_held", bus.key_held, 3'b011);
        bus.key_in = 3'b111;
        idle(12);
        check_int("t7_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
